// File: rtl/td4_sequencer.sv
// rtl/td4_sequencer.sv - TD4 program store with byte-stream loader and run/step execution gate
module td4_sequencer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load_start,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    output logic       o_load_ready,
    input  logic       i_run,
    input  logic       i_step,
    input  logic [3:0] i_pc,
    output logic [3:0] o_opcode,
    output logic [3:0] o_immediate,
    output logic       o_cpu_en,
    output logic       o_loaded,
    output logic [1:0] o_state,
    output logic [7:0] o_icount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_mem [16];
    logic [3:0] r_addr;
    logic       r_loaded;
    logic [7:0] r_icount;
    logic       r_step_q;

    logic       w_step_edge;
    logic       w_accept;
    logic       w_last_byte;
    logic       w_enter_load;
    logic [7:0] w_rd_byte;

    assign w_step_edge  = i_step & ~r_step_q;
    assign w_accept     = (r_state == ST_LOAD) & i_load_valid;
    assign w_last_byte  = w_accept & (r_addr == 4'd15);
    assign w_enter_load = (r_state != ST_LOAD) & (w_next_state == ST_LOAD);

    assign w_rd_byte    = r_mem[i_pc];
    assign o_opcode     = w_rd_byte[7:4];
    assign o_immediate  = w_rd_byte[3:0];
    assign o_load_ready = (r_state == ST_LOAD);
    assign o_cpu_en     = (r_state == ST_RUN) | (r_state == ST_STEP);
    assign o_loaded     = r_loaded;
    assign o_state      = r_state;
    assign o_icount     = r_icount;

    // STEP never samples load_start; a step is always a single enabled cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_last_byte) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_load_start)     w_next_state = ST_LOAD;
                else if (i_run)       w_next_state = ST_RUN;
                else if (w_step_edge) w_next_state = ST_STEP;
            end
            ST_RUN: begin
                if (i_load_start) w_next_state = ST_LOAD;
                else if (!i_run)  w_next_state = ST_IDLE;
            end
            ST_STEP: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_accept) begin
            r_mem[r_addr] <= i_load_data;
        end
    end

    // A reload restarts the image and the retired count; memory keeps stale bytes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= 4'd0;
            r_loaded <= 1'b0;
            r_icount <= 8'd0;
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= i_step;
            if (w_enter_load) begin
                r_addr   <= 4'd0;
                r_loaded <= 1'b0;
                r_icount <= 8'd0;
            end else begin
                if (w_accept) begin
                    r_addr <= r_addr + 4'd1;
                end
                if (w_last_byte) begin
                    r_loaded <= 1'b1;
                end
                if (o_cpu_en) begin
                    r_icount <= r_icount + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// tb/tb_td4_sequencer.sv - randomized and directed checks of td4_sequencer against a behavioural model
module tb_td4_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_load_start;
    logic       i_load_valid;
    logic [7:0] i_load_data;
    logic       o_load_ready;
    logic       i_run;
    logic       i_step;
    logic [3:0] i_pc;
    logic [3:0] o_opcode;
    logic [3:0] o_immediate;
    logic       o_cpu_en;
    logic       o_loaded;
    logic [1:0] o_state;
    logic [7:0] o_icount;

    td4_sequencer u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load_start (i_load_start),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .o_load_ready (o_load_ready),
        .i_run        (i_run),
        .i_step       (i_step),
        .i_pc         (i_pc),
        .o_opcode     (o_opcode),
        .o_immediate  (o_immediate),
        .o_cpu_en     (o_cpu_en),
        .o_loaded     (o_loaded),
        .o_state      (o_state),
        .o_icount     (o_icount)
    );

    always #5 i_clk = ~i_clk;

    localparam int MODE_IDLE = 0, MODE_LOAD = 1, MODE_RUN = 2, MODE_STEP = 3;

    int   n_cmp = 0;
    int   n_err = 0;

    int   m_mode;
    int   m_mem [16];
    int   m_addr;
    int   m_loaded;
    int   m_icount;
    int   m_step_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MODE_LOAD;
        m_addr   = 0;
        m_loaded = 0;
        m_icount = 0;
        m_step_q = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
    endtask

    // One clock of the program-store behaviour, from the mode rules in plain terms.
    task automatic model_clock();
        int  nxt;
        bit  fresh_step;
        bit  executing;
        fresh_step = i_step && !m_step_q;
        executing  = (m_mode == MODE_RUN) || (m_mode == MODE_STEP);
        m_step_q   = i_step;
        nxt        = m_mode;
        if (m_mode == MODE_LOAD) begin
            if (i_load_valid) begin
                m_mem[m_addr] = i_load_data;
                if (m_addr == 15) begin
                    m_loaded = 1;
                    m_addr   = 0;
                    nxt      = MODE_IDLE;
                end else begin
                    m_addr = m_addr + 1;
                end
            end
        end else if (m_mode == MODE_IDLE) begin
            if (i_load_start)    nxt = MODE_LOAD;
            else if (i_run)      nxt = MODE_RUN;
            else if (fresh_step) nxt = MODE_STEP;
        end else if (m_mode == MODE_RUN) begin
            if (i_load_start) nxt = MODE_LOAD;
            else if (!i_run)  nxt = MODE_IDLE;
        end else begin
            nxt = MODE_IDLE;
        end
        if (executing) m_icount = (m_icount + 1) % 256;
        if (nxt == MODE_LOAD && m_mode != MODE_LOAD) begin
            m_addr   = 0;
            m_loaded = 0;
            m_icount = 0;
        end
        m_mode = nxt;
    endtask

    task automatic check_outputs();
        check_eq("state",      o_state,      m_mode);
        check_eq("cpu_en",     o_cpu_en,     (m_mode == MODE_RUN || m_mode == MODE_STEP));
        check_eq("load_ready", o_load_ready, (m_mode == MODE_LOAD));
        check_eq("loaded",     o_loaded,     m_loaded);
        check_eq("icount",     o_icount,     m_icount);
        check_eq("opcode",     o_opcode,     (m_mem[i_pc] >> 4) & 15);
        check_eq("immediate",  o_immediate,  m_mem[i_pc] & 15);
    endtask

    task automatic tick();
        if (i_rst) model_reset();
        @(negedge i_clk);
        check_outputs();
        @(posedge i_clk);
        if (!i_rst) model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_data  = 8'h00;
        i_run        = 1'b0;
        i_step       = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_pc  = 4'd0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        i_rst = 1'b0;

        // Full load with valid held high.
        for (int i = 0; i < 16; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'(i);
            tick();
        end
        idle_inputs();
        i_pc = 4'd5;
        tick();
        check_eq("load_done_state", o_state, 0);
        check_eq("load_done_loaded", o_loaded, 1);
        check_eq("pc5_opcode", o_opcode, 0);
        check_eq("pc5_imm", o_immediate, 5);

        // Free-run for four sampled edges.
        i_run = 1'b1;
        repeat (4) tick();
        i_run = 1'b0;
        repeat (2) tick();
        check_eq("run4_icount", o_icount, 4);
        check_eq("run4_state", o_state, 0);

        // Held step yields one pulse; re-raise yields another.
        i_step = 1'b1;
        repeat (10) tick();
        check_eq("step_hold_icount", o_icount, 5);
        i_step = 1'b0;
        repeat (2) tick();
        i_step = 1'b1;
        repeat (3) tick();
        i_step = 1'b0;
        repeat (2) tick();
        check_eq("step_again_icount", o_icount, 6);

        // Reload requested while running.
        i_run = 1'b1;
        repeat (2) tick();
        i_load_start = 1'b1;
        tick();
        check_eq("reload_state", o_state, 1);
        check_eq("reload_cpu_en", o_cpu_en, 0);
        check_eq("reload_icount", o_icount, 0);
        check_eq("reload_loaded", o_loaded, 0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'hA0 + 8'(i);
            tick();
        end
        idle_inputs();
        i_pc = 4'd3;
        tick();
        check_eq("stale_byte3", {o_opcode, o_immediate}, 8'h03);
        i_pc = 4'd0;
        tick();
        check_eq("new_byte0", {o_opcode, o_immediate}, 8'hA0);

        // Finish this image, reload, then reset after 7 bytes.
        for (int i = 3; i < 16; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'($urandom);
            tick();
        end
        idle_inputs();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'hF0 | 8'(i);
            tick();
        end
        #3;
        i_rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_state", o_state, 1);
        check_eq("async_rst_loaded", o_loaded, 0);
        idle_inputs();
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_pc = 4'(i);
            tick();
            check_eq("rst_mem_zero", {o_opcode, o_immediate}, 8'h00);
        end

        // Fresh image, then 260 run cycles to exercise the count wrap.
        for (int i = 0; i < 16; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'($urandom);
            tick();
        end
        idle_inputs();
        i_run = 1'b1;
        repeat (260) tick();
        i_run = 1'b0;
        repeat (2) tick();
        check_eq("icount_wrap", o_icount, 4);

        // Random traffic across all modes, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            i_rst        = ($urandom_range(0, 599) == 0);
            i_load_start = ($urandom_range(0, 24) == 0);
            i_load_valid = $urandom_range(0, 1) == 1;
            i_load_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) i_run = ~i_run;
            i_step       = ($urandom_range(0, 2) == 0);
            i_pc         = 4'($urandom);
            tick();
        end
        i_rst = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
